// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, scan FSM states and a width helper shared by the
//   display scanner and its decoder.
package seg_pkg;
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic {GAP, SHOW} state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to {g,f,e,d,c,b,a} pattern; non-decimal codes show a dash.
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);
   always_comb begin
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed 7-segment scanner with tear-free BCD capture and anti-ghost gap.
//   Define SEG_ZERO_BLANK_EN to enable leading-zero blanking.
module bcd_seg_scan
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SLOT_CYC = 24000,
   parameter int GAP_CYC  = 24
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  ld,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_st
);
   localparam int CW = idx_w(SLOT_CYC);
   localparam int IW = idx_w(DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   state_t                r_state, w_state_nxt;
   logic                  r_started;
   logic [4*DIGITS-1:0]   r_pend, r_frame;
   logic                  r_pend_vld;
   logic [6:0]            r_seg;
   logic [DIGITS-1:0]     r_dig;
   logic                  r_fst;
   logic                  w_wrap, w_fs;
   logic [3:0]            w_digit;
   logic [6:0]            w_seg;
   logic [DIGITS-1:0]     w_blank;

   assign w_wrap  = r_cnt == CNT_LAST;
   // slot 0 straight out of reset is not a frame start
   assign w_fs    = r_started && r_cnt == '0 && r_idx == '0;
   assign w_digit = r_frame[4*r_idx +: 4];

   bcd_to_seg7 u_dec (.i_bcd(w_digit), .o_seg(w_seg));

`ifdef SEG_ZERO_BLANK_EN
   always_comb begin
      logic z;
      w_blank = '0;
      z = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         z = z && r_frame[4*k +: 4] == 4'd0;
         w_blank[k] = z;
      end
   end
`else
   assign w_blank = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == GAP && r_cnt == GAP_LAST) w_state_nxt = SHOW;
      else if (r_state == SHOW && w_wrap) w_state_nxt = GAP;
   end

   always_ff @(posedge clk) begin
      if (res) r_state <= GAP;
      else r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_started  <= 1'b0;
         r_pend     <= '0;
         r_frame    <= '0;
         r_pend_vld <= 1'b0;
         r_seg      <= SEG_OFF;
         r_dig      <= '1;
         r_fst      <= 1'b0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         if (w_wrap && r_idx == IDX_LAST) r_started <= 1'b1;
         if (w_fs) begin
            r_frame    <= ld ? bcd_in : (r_pend_vld ? r_pend : r_frame);
            r_pend_vld <= 1'b0;
         end else if (ld) begin
            r_pend     <= bcd_in;
            r_pend_vld <= 1'b1;
         end
         r_seg <= (r_state == SHOW && !w_blank[r_idx]) ? w_seg : SEG_OFF;
         r_dig <= (r_state == SHOW) ? ~(DIGITS'(1) << r_idx) : '1;
         r_fst <= w_fs;
      end
   end

   assign seg      = r_seg;
   assign dig_sel  = r_dig;
   assign frame_st = r_fst;
endmodule
